// File: rtl/bit_counter_hs.sv
// bit_counter_hs
// Iterative bit counter with valid/ready handshakes on input and output.
// Counts set bits, clear bits or trailing zeros by clearing one set bit
// per clock (work & (work - 1)).
// Optional feature macro: BITCNT_CYCLE_CNT_EN adds the cycle_cnt output,
// which reports how many clocks the block spent iterating.

module bit_counter_hs #(
    parameter  int N   = 8,
    localparam int CW  = $clog2(N + 1),
    localparam int CCW = $clog2(N + 2)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x_in,
    input  logic [1:0]    mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          busy
`ifdef BITCNT_CYCLE_CNT_EN
    ,
    output logic [CCW-1:0] cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic [N-1:0] work;
    logic [N-1:0] work_load;
    logic         accept;
    logic         release_result;

    // Operand transform applied at capture; mode 11 behaves like mode 00
    always_comb begin
        work_load = x_in;
        case (mode)
            2'b01:   work_load = ~x_in;
            2'b10:   work_load = ~x_in & (x_in - N'(1));
            default: work_load = x_in;
        endcase
    end

    // Handshake qualifiers and status outputs decoded from the state
    always_comb begin
        in_ready       = (state == IDLE);
        out_valid      = (state == DONE);
        busy           = (state == ITER) || (state == DONE);
        accept         = in_valid && (state == IDLE);
        release_result = out_ready && (state == DONE);
    end

    // Next-state logic; clr wins over any handshake, unused codes fall back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = ITER;
            ITER: if (work == '0) state_next = DONE;
            DONE: if (release_result) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clr) begin
            state_next = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Work register and result counter: load on accept, strip one set bit per ITER clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work  <= '0;
            count <= '0;
        end else if (clr) begin
            work  <= '0;
            count <= '0;
        end else if (accept) begin
            work  <= work_load;
            count <= '0;
        end else if ((state == ITER) && (work != '0)) begin
            work  <= work & (work - N'(1));
            count <= count + CW'(1);
        end
    end

`ifdef BITCNT_CYCLE_CNT_EN
    // Iteration clock counter: cleared on accept, bumped on every ITER clock, held afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt <= '0;
        end else if (clr) begin
            cycle_cnt <= '0;
        end else if (accept) begin
            cycle_cnt <= '0;
        end else if (state == ITER) begin
            cycle_cnt <= cycle_cnt + CCW'(1);
        end
    end
`endif

endmodule
